// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM encoding,
// default payload width and the idle level of the serial line.
package fifo_uart_pkg;

  localparam int   DATA_W_DEF  = 8;
  localparam logic TX_IDLE_LVL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port plus serial-side status, bundled as one interface.
// slave = the transmitter, master = whoever drives the FIFO side.
interface fifo_uart_tx_if #(
  parameter int DATA_W = fifo_uart_pkg::DATA_W_DEF
);
  logic              en;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd;
  logic              tx;
  logic              busy;
  logic              tx_done;

  modport master (
    output en, fifo_empty, fifo_data,
    input  fifo_rd, tx, busy, tx_done
  );

  modport slave (
    input  en, fifo_empty, fifo_data,
    output fifo_rd, tx, busy, tx_done
  );
endinterface

// File: rtl/fifo_uart_tx_baud_tick.sv
// Bit-period counter: o_tick is high for one cycle every CLKS_PER_BIT cycles;
// i_clr restarts the period so a frame always begins on a full bit.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);
  localparam int                CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  TERM  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = (r_cnt == TERM);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a synchronous FIFO and sends them as 8N1 frames; tx/busy are
// registered and track the next state. Define FIFO_UART_TX_PARITY_EN for an even-parity bit.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = DATA_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  fifo_uart_tx_if.slave  bus
);
  localparam int               BIT_W    = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_START  = ST_START;
  localparam logic [2:0] S_DATA   = ST_DATA;
  localparam logic [2:0] S_STOP   = ST_STOP;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = ST_PARITY;
  logic                  r_par;
`endif

  logic [2:0]        r_state, w_state_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic [BIT_W-1:0]  r_bit,   w_bit_nxt;
  logic              r_tx,    w_tx_nxt;
  logic              r_busy;
  logic              w_tick;
  logic              w_pop;

  // rst is folded in so the FIFO never sees a read while we are held in reset.
  assign w_pop = (r_state == S_IDLE) & bus.en & ~bus.fifo_empty & rst;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clr  (w_pop),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_state_nxt = S_START;
          w_shift_nxt = bus.fifo_data;
        end
      end
      S_START: begin
        if (w_tick) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit == LAST_BIT) begin
            w_bit_nxt = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_nxt = r_bit + BIT_W'(1);
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_tick) w_state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_tick) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Line level is derived from the next state so tx lines up with the state register.
  always_comb begin
    w_tx_nxt = TX_IDLE_LVL;
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: w_tx_nxt = r_par;
`endif
      default:  w_tx_nxt = TX_IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_tx    <= TX_IDLE_LVL;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_bit   <= w_bit_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

`ifdef FIFO_UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_par <= 1'b0;
    end else if (w_pop) begin
      r_par <= ^bus.fifo_data;
    end
  end
`endif

  assign bus.fifo_rd = w_pop;
  assign bus.tx      = r_tx;
  assign bus.busy    = r_busy;
  assign bus.tx_done = (r_state == S_STOP) & w_tick;

endmodule
